pe_stream_ctrl: RTL and testbench
=================================

// Module: pe_stream_ctrl
// PURPOSE
//  Host-side driver for one PE_new lane. Reads a KxK filter and an AxA activation tile from a shared
//  global buffer, streams them over the PE's filt_in/act_in load interface, and issues one start per
//  output row. It then collects each row's pe_out on compute_done and forwards it downstream.
//  Sits between the global buffer and one PE; one job per go pulse.
// PARAMETERS
//  DATA_BITWIDTH      16   width of weights, activations and psums
//  BUF_ADDR_BITWIDTH  10   global buffer address width
//  KERNEL_SIZE        3    filter edge K; weight words per job = K*K
//  ACT_SIZE           5    activation edge A; act words = A*A; rows R = A-K+1
//  TIMEOUT            255  max cycles waited for load_done/compute_done before error
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  go             in   1      job request; sampled only in IDLE
//  wght_base      in   BUF_ADDR_BITWIDTH  buffer address of weight word 0 (latched on go)
//  act_base       in   BUF_ADDR_BITWIDTH  buffer address of activation word 0 (latched on go)
//  buf_rd_en      out  1      buffer read strobe
//  buf_rd_addr    out  BUF_ADDR_BITWIDTH  buffer read address
//  buf_rd_data    in   DATA_BITWIDTH      read data, valid exactly 1 cycle after buf_rd_en
//  load_en_wght   out  1      to PE: 1-cycle pulse marking weight word 0
//  load_en_act    out  1      to PE: 1-cycle pulse marking activation word 0
//  filt_in        out  DATA_BITWIDTH  to PE: weight stream (= buf_rd_data while streaming weights, else 0)
//  act_in         out  DATA_BITWIDTH  to PE: activation stream (= buf_rd_data while streaming acts, else 0)
//  start          out  1      to PE: 1-cycle row-compute pulse
//  load_done      in   1      from PE: load phase complete
//  compute_done   in   1      from PE: row result valid on pe_out
//  pe_out         in   DATA_BITWIDTH  from PE: row psum
//  psum_valid     out  1      1-cycle pulse: psum_data/psum_row valid
//  psum_data      out  DATA_BITWIDTH  captured pe_out
//  psum_row       out  3      row index 0..R-1
//  busy           out  1      high from accepted go until done/err
//  done           out  1      1-cycle pulse at job end
//  err            out  1      sticky timeout flag; cleared by reset or next accepted go
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0. Reset mid-job aborts immediately, no done pulse.
//    PE shares reset, so both ends restart aligned.
//  - FSM: IDLE -> W_PRIME -> W_STREAM -> W_WAIT -> A_PRIME -> A_STREAM -> A_WAIT
//    -> (START -> C_WAIT -> GAP) x R -> WRAP -> IDLE.
//    Any *_WAIT state hitting TIMEOUT -> ERR (err=1, busy=0) -> IDLE.
//  - IDLE: on go, latch bases, busy=1, err=0. go while busy is ignored.
//  - PRIME: buf_rd_en=1, addr=base+0.
//  - STREAM, cycle k=0..N-1: drive word k combinationally from buf_rd_data. Assert load_en_* only at
//    k=0. Prefetch addr base+k+1 while k<N-1. Exactly N consecutive cycles, no bubbles: the PE samples
//    one word per cycle.
//  - WAIT: hold load_en/start low until load_done=1.
//  - Weights are always loaded before activations, every job. The PE's word counter is only cleared
//    by the weight load.
//  - START: start=1 for one cycle.
//  - C_WAIT: on the first cycle compute_done=1, register pe_out -> psum_data, row -> psum_row,
//    psum_valid=1.
//  - GAP: start=0 for one cycle so the PE clears compute_done. Then row++; if row<R -> START, else WRAP.
//  - WRAP: extra 1-cycle start so the PE resets its row iterator. No compute_done expected.
//    done=1 next cycle, busy=0.
//  - Timeout counter: 8 bits, reset on every WAIT entry, saturates; compared == TIMEOUT.
//  - Address arithmetic: unsigned, wraps modulo 2^BUF_ADDR_BITWIDTH.
//  - psum_data is passed through unmodified; no width change.
// STRUCTURE
//  - Shared package pe_pkg: FSM state localparams, PE load-protocol constants (word counts K*K, A*A,
//    rows R).
//  - One natural sub-module: buf_burst_reader (base, len, go -> rd_en/addr stream plus word index and
//    last flag). Reused for weight and activation phases.
// TESTING (bench pairs this block with PE_new and a behavioural 1-cycle-latency buffer, K=3, A=5)
//  1 Weights 1..9 at 0x000, acts 1..25 at 0x064, go -> PE receives 9+25 words back-to-back;
//    3 psum_valid pulses; psum_row 0,1,2; data matches a golden model of the PE's per-row dot products
//    (same address pattern); done 1 cycle after WRAP.
//  2 Check load_en_wght high exactly 1 cycle with filt_in=1; buf_rd_addr 0..8 consecutive;
//    load_en_act pulses once with act_in=1.
//  3 Two back-to-back jobs with different bases -> second job's psums correct; confirms WRAP reset
//    the PE iterator.
//  4 Bench-forced load_done stuck 0 -> err=1 after 255 wait cycles, busy=0, no done;
//    next go clears err.
//  5 go held high during job -> ignored, exactly one job; reset asserted in A_STREAM -> all outputs 0
//    next cycle, fresh go completes normally.
//  6 go pulsed in same cycle reset deasserts -> go ignored (state still IDLE first cycle), busy stays 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants for the PE stream controller: FSM encodings, counter widths and
// the PE load-protocol word counts derived from the filter/activation geometry.
package pe_pkg;

    localparam int STATE_W = 4;
    localparam int TMO_W   = 8;
    localparam int LEN_W   = 8;

    localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] S_W_PRIME  = 4'd1;
    localparam logic [STATE_W-1:0] S_W_STREAM = 4'd2;
    localparam logic [STATE_W-1:0] S_W_WAIT   = 4'd3;
    localparam logic [STATE_W-1:0] S_A_PRIME  = 4'd4;
    localparam logic [STATE_W-1:0] S_A_STREAM = 4'd5;
    localparam logic [STATE_W-1:0] S_A_WAIT   = 4'd6;
    localparam logic [STATE_W-1:0] S_START    = 4'd7;
    localparam logic [STATE_W-1:0] S_C_WAIT   = 4'd8;
    localparam logic [STATE_W-1:0] S_GAP      = 4'd9;
    localparam logic [STATE_W-1:0] S_WRAP     = 4'd10;
    localparam logic [STATE_W-1:0] S_ERR      = 4'd11;

    function automatic int wght_words(input int k);
        return k * k;
    endfunction

    function automatic int act_words(input int a);
        return a * a;
    endfunction

    function automatic int out_rows(input int k, input int a);
        return a - k + 1;
    endfunction

endpackage

// File: rtl/buf_burst_reader.sv
// Issues a gap-free burst of buffer reads: the start cycle reads base, then each active
// cycle presents word idx (arriving on the buffer's 1-cycle read data) and prefetches idx+1.
module buf_burst_reader
    import pe_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              active,
    output logic [CNT_W-1:0]  idx,
    output logic              last
);

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            idx    <= '0;
            base_q <= '0;
            len_q  <= '0;
        end else if (start) begin
            active <= 1'b1;
            idx    <= '0;
            base_q <= base;
            len_q  <= len;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
                idx    <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign last  = active && (idx == len_q - 1'b1);
    assign rd_en = start || (active && !last);

    // Address arithmetic wraps naturally at the buffer size.
    always_comb begin
        rd_addr = '0;
        if (start)
            rd_addr = base;
        else if (rd_en)
            rd_addr = base_q + ADDR_W'(idx) + ADDR_W'(1);
    end

endmodule

// File: rtl/pe_stream_ctrl.sv
// Host-side sequencer for one PE lane: loads weights then activations from the global
// buffer, runs one start per output row, forwards each row psum and closes with a wrap start.
//   state    | meaning
//   IDLE     | waiting for go
//   W_PRIME  | read weight word 0
//   W_STREAM | stream K*K weights to the PE
//   W_WAIT   | wait for load_done after weights
//   A_PRIME  | read activation word 0
//   A_STREAM | stream A*A activations to the PE
//   A_WAIT   | wait for load_done after activations
//   START    | one-cycle row start
//   C_WAIT   | wait for compute_done, capture pe_out
//   GAP      | start low so the PE drops compute_done
//   WRAP     | extra start that rewinds the PE row iterator
//   ERR      | timeout seen, back to IDLE
module pe_stream_ctrl
    import pe_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int BUF_ADDR_BITWIDTH = 10,
    parameter int KERNEL_SIZE       = 3,
    parameter int ACT_SIZE          = 5,
    parameter int TIMEOUT           = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic [BUF_ADDR_BITWIDTH-1:0] wght_base,
    input  logic [BUF_ADDR_BITWIDTH-1:0] act_base,
    output logic                         buf_rd_en,
    output logic [BUF_ADDR_BITWIDTH-1:0] buf_rd_addr,
    input  logic [DATA_BITWIDTH-1:0]     buf_rd_data,
    output logic                         load_en_wght,
    output logic                         load_en_act,
    output logic [DATA_BITWIDTH-1:0]     filt_in,
    output logic [DATA_BITWIDTH-1:0]     act_in,
    output logic                         start,
    input  logic                         load_done,
    input  logic                         compute_done,
    input  logic [DATA_BITWIDTH-1:0]     pe_out,
    output logic                         psum_valid,
    output logic [DATA_BITWIDTH-1:0]     psum_data,
    output logic [2:0]                   psum_row,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int         N_W      = wght_words(KERNEL_SIZE);
    localparam int         N_A      = act_words(ACT_SIZE);
    localparam int         N_R      = out_rows(KERNEL_SIZE, ACT_SIZE);
    localparam logic [2:0] LAST_ROW = 3'(N_R - 1);

    logic [STATE_W-1:0]           state;
    logic [BUF_ADDR_BITWIDTH-1:0] wght_base_q;
    logic [BUF_ADDR_BITWIDTH-1:0] act_base_q;
    logic [TMO_W-1:0]             tmo_cnt;
    logic [TMO_W-1:0]             tmo_inc;
    logic                         tmo_hit;
    logic [2:0]                   row;

    logic                         rd_start;
    logic [BUF_ADDR_BITWIDTH-1:0] rd_base;
    logic [LEN_W-1:0]             rd_len;
    logic                         rd_active;
    logic [LEN_W-1:0]             rd_idx;
    logic                         rd_last;

    assign rd_start = (state == S_W_PRIME) || (state == S_A_PRIME);
    assign rd_base  = (state == S_W_PRIME) ? wght_base_q : act_base_q;
    assign rd_len   = (state == S_W_PRIME) ? LEN_W'(N_W) : LEN_W'(N_A);

    buf_burst_reader #(
        .ADDR_W (BUF_ADDR_BITWIDTH),
        .CNT_W  (LEN_W)
    ) u_reader (
        .clk     (clk),
        .reset   (reset),
        .start   (rd_start),
        .base    (rd_base),
        .len     (rd_len),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .active  (rd_active),
        .idx     (rd_idx),
        .last    (rd_last)
    );

    // The stream states coincide with the reader's active window, one word per cycle.
    assign filt_in      = (state == S_W_STREAM) ? buf_rd_data : '0;
    assign act_in       = (state == S_A_STREAM) ? buf_rd_data : '0;
    assign load_en_wght = (state == S_W_STREAM) && rd_active && (rd_idx == '0);
    assign load_en_act  = (state == S_A_STREAM) && rd_active && (rd_idx == '0);
    assign start        = (state == S_START) || (state == S_WRAP);
    assign busy         = (state != S_IDLE) && (state != S_ERR);

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT));
    assign tmo_inc = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wght_base_q <= '0;
            act_base_q  <= '0;
            tmo_cnt     <= '0;
            row         <= '0;
            psum_valid  <= 1'b0;
            psum_data   <= '0;
            psum_row    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            psum_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    wght_base_q <= wght_base;
                    act_base_q  <= act_base;
                    err         <= 1'b0;
                    row         <= '0;
                    state       <= S_W_PRIME;
                end
                S_W_PRIME:  state <= S_W_STREAM;
                S_W_STREAM: if (rd_last) begin
                    tmo_cnt <= '0;
                    state   <= S_W_WAIT;
                end
                S_W_WAIT: begin
                    if (load_done)    state <= S_A_PRIME;
                    else if (tmo_hit) begin state <= S_ERR; err <= 1'b1; end
                    else              tmo_cnt <= tmo_inc;
                end
                S_A_PRIME:  state <= S_A_STREAM;
                S_A_STREAM: if (rd_last) begin
                    tmo_cnt <= '0;
                    state   <= S_A_WAIT;
                end
                S_A_WAIT: begin
                    if (load_done)    state <= S_START;
                    else if (tmo_hit) begin state <= S_ERR; err <= 1'b1; end
                    else              tmo_cnt <= tmo_inc;
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_C_WAIT;
                end
                S_C_WAIT: begin
                    if (compute_done) begin
                        psum_valid <= 1'b1;
                        psum_data  <= pe_out;
                        psum_row   <= row;
                        state      <= S_GAP;
                    end else if (tmo_hit) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                S_GAP: begin
                    if (row == LAST_ROW) begin
                        state <= S_WRAP;
                    end else begin
                        row   <= row + 1'b1;
                        state <= S_START;
                    end
                end
                S_WRAP: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Directed bench for pe_stream_ctrl with a behavioural 1-cycle buffer and a small PE lane model.
module tb_pe_stream_ctrl;
    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [AW-1:0] wght_base;
    logic [AW-1:0] act_base;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [DW-1:0] buf_rd_data;
    logic          load_en_wght;
    logic          load_en_act;
    logic [DW-1:0] filt_in;
    logic [DW-1:0] act_in;
    logic          start;
    logic          load_done;
    logic          compute_done;
    logic [DW-1:0] pe_out;
    logic          psum_valid;
    logic [DW-1:0] psum_data;
    logic [2:0]    psum_row;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_stream_ctrl dut (
        .clk(clk), .reset(reset), .go(go), .wght_base(wght_base), .act_base(act_base),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .load_en_wght(load_en_wght), .load_en_act(load_en_act), .filt_in(filt_in), .act_in(act_in),
        .start(start), .load_done(load_done), .compute_done(compute_done), .pe_out(pe_out),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_row(psum_row),
        .busy(busy), .done(done), .err(err)
    );

    // Global buffer, read data one cycle after the strobe.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

    // PE lane model: word counter cleared by the weight load, row iterator rewound by the extra start.
    logic [DW-1:0] pe_w [0:8];
    logic [DW-1:0] pe_a [0:24];
    logic [DW-1:0] pe_res;
    logic          pe_ld;
    logic          ld_stuck;
    int pe_cnt, pe_row, pe_lat, cd_cnt;

    function automatic logic [DW-1:0] pe_dot(input int r);
        logic [DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc = acc + pe_w[i*3+j] * pe_a[(r+i)*5+j];
        return acc;
    endfunction

    assign load_done    = pe_ld & ~ld_stuck;
    assign compute_done = (cd_cnt > 0);
    assign pe_out       = (cd_cnt > 0) ? pe_res : 16'hDEAD;

    always @(posedge clk) begin
        if (reset) begin
            pe_cnt <= 0; pe_row <= 0; pe_lat <= 0; cd_cnt <= 0; pe_ld <= 1'b0; pe_res <= '0;
        end else begin
            pe_ld <= 1'b0;
            if (load_en_wght) begin
                pe_w[0] <= filt_in; pe_cnt <= 1;
            end else if (pe_cnt >= 1 && pe_cnt <= 8) begin
                pe_w[pe_cnt] <= filt_in; pe_cnt <= pe_cnt + 1;
                if (pe_cnt == 8) pe_ld <= 1'b1;
            end else if (pe_cnt == 9 && load_en_act) begin
                pe_a[0] <= act_in; pe_cnt <= 10;
            end else if (pe_cnt >= 10 && pe_cnt <= 33) begin
                pe_a[pe_cnt-9] <= act_in; pe_cnt <= pe_cnt + 1;
                if (pe_cnt == 33) pe_ld <= 1'b1;
            end
            if (cd_cnt > 0) cd_cnt <= cd_cnt - 1;
            if (start) begin
                if (pe_row < 3) begin
                    pe_res <= pe_dot(pe_row); pe_row <= pe_row + 1; pe_lat <= 3;
                end else begin
                    pe_row <= 0;
                end
            end else if (pe_lat > 0) begin
                pe_lat <= pe_lat - 1;
                if (pe_lat == 1) cd_cnt <= 2;
            end
        end
    end

    // Event log sampled on the falling edge.
    int cyc = 0, done_cnt = 0, lw_cnt = 0, la_cnt = 0, last_start_cyc = 0, done_cyc = 0;
    logic [DW-1:0] lw_filt, la_act;
    logic [DW-1:0] pv_data [$];
    logic [2:0]    pv_row  [$];
    logic [AW-1:0] addr_log [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (psum_valid) begin pv_data.push_back(psum_data); pv_row.push_back(psum_row); end
        if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
        if (start) last_start_cyc <= cyc;
        if (load_en_wght) begin lw_cnt <= lw_cnt + 1; lw_filt <= filt_in; end
        if (load_en_act) begin la_cnt <= la_cnt + 1; la_act <= act_in; end
        if (buf_rd_en && !reset) addr_log.push_back(buf_rd_addr);
    end

    task automatic run_job(input logic [AW-1:0] wb, input logic [AW-1:0] ab);
        int n;
        @(negedge clk);
        wght_base = wb; act_base = ab; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        #1;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL job_done: done=%b after %0d cycles, required 1", done, n); end
    endtask

    task automatic test_reset;
        reset = 1'b1; go = 1'b0; wght_base = '0; act_base = '0; ld_stuck = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({buf_rd_en, buf_rd_addr, load_en_wght, load_en_act, filt_in, act_in, start, psum_valid,
             psum_data, psum_row, busy, done, err} !== '0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero (busy=%b err=%b rd_en=%b), required all 0", busy, err, buf_rd_en);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_single_job;
        int p0, d0;
        logic [DW-1:0] exp_d [3];
        exp_d = '{16'd411, 16'd636, 16'd861};
        p0 = pv_data.size(); d0 = done_cnt;
        run_job(10'h000, 10'h064);
        total++;
        if (pv_data.size() - p0 != 3) begin bad++; $display("FAIL psum_count: got %0d, required 3", pv_data.size() - p0); end
        for (int r = 0; r < 3; r++) begin
            if (pv_data.size() > p0 + r) begin
                total++;
                if (pv_row[p0+r] !== 3'(r)) begin bad++; $display("FAIL psum_row%0d: got %0d, required %0d", r, pv_row[p0+r], r); end
                total++;
                if (pv_data[p0+r] !== exp_d[r]) begin bad++; $display("FAIL psum_data%0d: got %0d, required %0d", r, pv_data[p0+r], exp_d[r]); end
            end
        end
        total++;
        if (done_cyc - last_start_cyc != 1) begin bad++; $display("FAIL done_after_wrap: gap=%0d, required 1", done_cyc - last_start_cyc); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_pulses: got %0d, required 1", done_cnt - d0); end
        total++;
        if (pe_cnt != 34) begin bad++; $display("FAIL pe_words: got %0d, required 34", pe_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done: got %b, required 0", busy); end
    endtask

    task automatic test_load_stream;
        int w0, a0, l0;
        w0 = lw_cnt; a0 = la_cnt; l0 = addr_log.size();
        run_job(10'h000, 10'h064);
        total++;
        if (lw_cnt - w0 != 1) begin bad++; $display("FAIL load_en_wght_cycles: got %0d, required 1", lw_cnt - w0); end
        total++;
        if (lw_filt !== 16'd1) begin bad++; $display("FAIL filt_at_load_en: got %0d, required 1", lw_filt); end
        total++;
        if (la_cnt - a0 != 1) begin bad++; $display("FAIL load_en_act_cycles: got %0d, required 1", la_cnt - a0); end
        total++;
        if (la_act !== 16'd1) begin bad++; $display("FAIL act_at_load_en: got %0d, required 1", la_act); end
        total++;
        if (addr_log.size() - l0 != 34) begin bad++; $display("FAIL read_count: got %0d, required 34", addr_log.size() - l0); end
        for (int k = 0; k < 34; k++) begin
            if (addr_log.size() > l0 + k) begin
                total++;
                if (addr_log[l0+k] !== ((k < 9) ? 10'(k) : 10'(10'h064 + k - 9))) begin
                    bad++; $display("FAIL rd_addr%0d: got %h, required %h", k, addr_log[l0+k], (k < 9) ? 10'(k) : 10'(10'h064 + k - 9));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int p0, l0;
        logic [DW-1:0] exp_d [6];
        exp_d = '{16'd411, 16'd636, 16'd861, 16'd452, 16'd662, 16'd872};
        p0 = pv_data.size();
        run_job(10'h000, 10'h064);
        l0 = addr_log.size();
        run_job(10'h3FD, 10'h100);
        total++;
        if (pv_data.size() - p0 != 6) begin bad++; $display("FAIL b2b_psum_count: got %0d, required 6", pv_data.size() - p0); end
        for (int r = 0; r < 6; r++) begin
            if (pv_data.size() > p0 + r) begin
                total++;
                if (pv_data[p0+r] !== exp_d[r] || pv_row[p0+r] !== 3'(r % 3)) begin
                    bad++; $display("FAIL b2b_psum%0d: got %0d row %0d, required %0d row %0d", r, pv_data[p0+r], pv_row[p0+r], exp_d[r], r % 3);
                end
            end
        end
        if (addr_log.size() > l0 + 3) begin
            total++;
            if (addr_log[l0] !== 10'h3FD || addr_log[l0+3] !== 10'h000) begin
                bad++; $display("FAIL addr_wrap: got %h,%h, required 3fd,000", addr_log[l0], addr_log[l0+3]);
            end
        end
    endtask

    task automatic test_timeout;
        int n, d0, p0;
        logic [DW-1:0] exp_d [3];
        exp_d = '{16'd452, 16'd662, 16'd872};
        d0 = done_cnt;
        ld_stuck = 1'b1;
        @(negedge clk);
        wght_base = 10'h3FD; act_base = 10'h100; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (load_en_wght !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (err !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        total++;
        if (n != 265) begin bad++; $display("FAIL err_latency: got %0d cycles, required 265", n); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_on_err: got %b, required 0", busy); end
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b, required 1", err); end
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL done_on_err: got %0d pulses, required 0", done_cnt - d0); end
        ld_stuck = 1'b0;
        p0 = pv_data.size();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_clear_on_go: err=%b busy=%b, required 0 1", err, busy); end
        n = 0;
        while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        #1;
        total++;
        if (pv_data.size() - p0 != 3) begin bad++; $display("FAIL recovery_psum_count: got %0d, required 3", pv_data.size() - p0); end
        for (int r = 0; r < 3; r++) begin
            if (pv_data.size() > p0 + r) begin
                total++;
                if (pv_data[p0+r] !== exp_d[r]) begin bad++; $display("FAIL recovery_psum%0d: got %0d, required %0d", r, pv_data[p0+r], exp_d[r]); end
            end
        end
    endtask

    task automatic test_go_held_and_reset;
        int n, d0, p0;
        logic [DW-1:0] exp_d [3];
        exp_d = '{16'd411, 16'd636, 16'd861};
        d0 = done_cnt; p0 = pv_data.size();
        @(negedge clk);
        wght_base = 10'h000; act_base = 10'h064; go = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_job: got %b, required 1", busy); end
        repeat (30) @(negedge clk);
        go = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        #1;
        total++;
        if (done_cnt - d0 != 1 || pv_data.size() - p0 != 3) begin
            bad++; $display("FAIL go_held_one_job: done=%0d psums=%0d, required 1 and 3", done_cnt - d0, pv_data.size() - p0);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL go_held_idle: busy=%b, required 0", busy); end

        d0 = done_cnt;
        @(negedge clk);
        wght_base = 10'h3FD; act_base = 10'h100; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (load_en_act !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({buf_rd_en, buf_rd_addr, load_en_wght, load_en_act, filt_in, act_in, start, psum_valid,
             psum_data, psum_row, busy, done, err} !== '0) begin
            bad++; $display("FAIL midjob_reset: busy=%b rd_en=%b act_in=%h, required all 0", busy, buf_rd_en, act_in);
        end
        reset = 1'b0;
        p0 = pv_data.size();
        run_job(10'h000, 10'h064);
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL abort_no_done: got %0d pulses, required 1", done_cnt - d0); end
        for (int r = 0; r < 3; r++) begin
            if (pv_data.size() > p0 + r) begin
                total++;
                if (pv_data[p0+r] !== exp_d[r]) begin bad++; $display("FAIL post_reset_psum%0d: got %0d, required %0d", r, pv_data[p0+r], exp_d[r]); end
            end
        end
    endtask

    task automatic test_go_at_reset_release;
        @(negedge clk);
        reset = 1'b1; go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        reset = 1'b0; go = 1'b0;
        total++;
        if (busy !== 1'b0 || buf_rd_en !== 1'b0) begin bad++; $display("FAIL go_in_reset_first: busy=%b rd_en=%b, required 0 0", busy, buf_rd_en); end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || load_en_wght !== 1'b0) begin bad++; $display("FAIL go_in_reset_later: busy=%b load_en_wght=%b, required 0 0", busy, load_en_wght); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int k = 0; k < 9; k++)  mem[k] = 16'(k + 1);
        for (int k = 0; k < 25; k++) mem[10'h064 + k] = 16'(k + 1);
        for (int k = 0; k < 25; k++) mem[10'h100 + k] = 16'(2 * (k + 1));
        test_reset();
        test_single_job();
        test_load_stream();
        test_back_to_back();
        test_timeout();
        test_go_held_and_reset();
        test_go_at_reset_release();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
